// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size codes,
// supported data-path widths and the funct3 size decode helper.
// No ports; imported by load_store_unit and lsu_lane_shifter.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ0,
      ST_WAIT0,
      ST_REQ1,
      ST_WAIT1,
      ST_RESP
   } lsu_state_t;

   // funct3[1:0] access-size codes
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   localparam int XLEN_32 = 32;
   localparam int XLEN_64 = 64;

   function automatic logic xlen_legal(input int xlen);
      return (xlen == XLEN_32) || (xlen == XLEN_64);
   endfunction

   // Access size in bytes; a doubleword request on a 32-bit path degrades to a word.
   function automatic logic [3:0] size_bytes(input logic [1:0] sz, input int xlen);
      case (sz)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         SZ_D:    return (xlen == XLEN_64) ? 4'd8 : 4'd4;
         default: return 4'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_shifter.sv
// Byte-granular barrel shifter used to move data between byte lanes.
// Purely combinational, zero latency; no flow control.
// Ports: din (data), nbytes (shift in bytes, may equal XLEN/8), right (1 = shift right), dout.
module lsu_lane_shifter
   import lsu_pkg::*;
#(
   parameter int XLEN = XLEN_32,
   parameter int AW   = $clog2(XLEN / 8) + 1
) (
   input  logic [XLEN-1:0] din,
   input  logic [AW-1:0]   nbytes,
   input  logic            right,
   output logic [XLEN-1:0] dout
);

   logic [AW+2:0] nbits;

   assign nbits = {nbytes, 3'b000};
   // A shift of the full width yields zero, which the beat-1 paths rely on.
   assign dout  = right ? (din >> nbits) : (din << nbits);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline access into one or two aligned memory beats.
// Latency: aligned store 2 cycles, aligned load 3 cycles from i_req (+1/+2 per extra beat).
// Backpressure: o_dmem_req held stable until i_dmem_gnt; loads wait for i_dmem_rvalid; o_busy stalls the pipeline.
// Ports: pipeline side i_req/i_mem_read/i_mem_write/i_funct3/i_addr/i_wdata -> o_busy/o_done/o_load_data/o_misaligned;
//        memory side o_dmem_req/addr/ren/wen/wdata/mask <- i_dmem_gnt, i_dmem_rvalid/i_dmem_rdata.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int MISALIGN_SPLIT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [2:0]        i_funct3,
   input  logic [XLEN-1:0]   i_addr,
   input  logic [XLEN-1:0]   i_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [XLEN-1:0]   o_load_data,
   output logic              o_misaligned,
   output logic              o_dmem_req,
   input  logic              i_dmem_gnt,
   output logic [XLEN-1:0]   o_dmem_addr,
   output logic              o_dmem_ren,
   output logic              o_dmem_wen,
   output logic [XLEN-1:0]   o_dmem_wdata,
   output logic [XLEN/8-1:0] o_dmem_mask,
   input  logic              i_dmem_rvalid,
   input  logic [XLEN-1:0]   i_dmem_rdata
);

   localparam int B  = XLEN / 8;
   localparam int OW = $clog2(B);
   localparam int AW = OW + 1;
   localparam int MW = 2 * B;

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("load_store_unit: XLEN must be 32 or 64");
   end

   // Byte-enable pattern spanning two words: low half is beat 0, high half beat 1.
   function automatic logic [MW-1:0] mask_wide(input logic [OW-1:0] off, input logic [3:0] sz);
      logic [MW-1:0] m;
      m = (MW'(1) << sz) - MW'(1);
      return m << off;
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [3:0] sz,
                                              input logic uns);
      logic [XLEN-1:0] keep;
      logic [XLEN-1:0] top;
      logic            sgn;
      keep = (XLEN'(1) << {sz, 3'b000}) - XLEN'(1);
      top  = keep & ~(keep >> 1);
      sgn  = ~uns & (|(d & top));
      return (d & keep) | ({XLEN{sgn}} & ~keep);
   endfunction

   lsu_state_t      state;
   logic [OW-1:0]   req_off;
   logic [3:0]      req_size;
   logic            req_cross, req_load, req_uns;
   logic [XLEN-1:0] req_wdata, rdata0_q;

   logic [OW-1:0]   in_off, mask_off;
   logic [3:0]      in_size, mask_size;
   logic            in_cross, in_valid;
   logic [MW-1:0]   mask_w;
   logic [AW-1:0]   hi_amt;
   logic [XLEN-1:0] wdata0, wdata1, rd_lo_src, rd_lo, rd_hi, load_val;

   assign in_off   = i_addr[OW-1:0];
   assign in_size  = size_bytes(i_funct3[1:0], XLEN);
   assign in_cross = (int'(in_off) + int'(in_size)) > B;
   assign in_valid = i_req & (i_mem_read | i_mem_write);

   // In IDLE the mask is built for the incoming beat 0; later for the registered beat 1.
   assign mask_off  = (state == ST_IDLE) ? in_off  : req_off;
   assign mask_size = (state == ST_IDLE) ? in_size : req_size;
   assign mask_w    = mask_wide(mask_off, mask_size);
   assign hi_amt    = AW'(B) - {1'b0, req_off};

   lsu_lane_shifter #(.XLEN(XLEN), .AW(AW)) u_wdata0 (
      .din(i_wdata), .nbytes({1'b0, in_off}), .right(1'b0), .dout(wdata0));
   lsu_lane_shifter #(.XLEN(XLEN), .AW(AW)) u_wdata1 (
      .din(req_wdata), .nbytes(hi_amt), .right(1'b1), .dout(wdata1));

   // A single-beat load completes straight from the live return data.
   assign rd_lo_src = (state == ST_WAIT0) ? i_dmem_rdata : rdata0_q;

   lsu_lane_shifter #(.XLEN(XLEN), .AW(AW)) u_rdata0 (
      .din(rd_lo_src), .nbytes({1'b0, req_off}), .right(1'b1), .dout(rd_lo));
   lsu_lane_shifter #(.XLEN(XLEN), .AW(AW)) u_rdata1 (
      .din(i_dmem_rdata), .nbytes(hi_amt), .right(1'b0), .dout(rd_hi));

   assign load_val = extend(rd_lo | (req_cross ? rd_hi : '0), req_size, req_uns);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         req_off      <= '0;
         req_size     <= '0;
         req_cross    <= 1'b0;
         req_load     <= 1'b0;
         req_uns      <= 1'b0;
         req_wdata    <= '0;
         rdata0_q     <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         o_load_data  <= '0;
         o_dmem_req   <= 1'b0;
         o_dmem_addr  <= '0;
         o_dmem_ren   <= 1'b0;
         o_dmem_wen   <= 1'b0;
         o_dmem_wdata <= '0;
         o_dmem_mask  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  req_off   <= in_off;
                  req_size  <= in_size;
                  req_cross <= in_cross;
                  req_load  <= i_mem_read;
                  req_uns   <= i_funct3[2];
                  req_wdata <= i_wdata;
                  o_busy    <= 1'b1;
                  if (in_cross && (MISALIGN_SPLIT == 0)) begin
                     state        <= ST_RESP;
                     o_done       <= 1'b1;
                     o_misaligned <= 1'b1;
                     o_load_data  <= '0;
                  end else begin
                     state        <= ST_REQ0;
                     o_dmem_req   <= 1'b1;
                     o_dmem_addr  <= {i_addr[XLEN-1:OW], {OW{1'b0}}};
                     o_dmem_ren   <= i_mem_read;
                     o_dmem_wen   <= ~i_mem_read;
                     o_dmem_wdata <= wdata0;
                     o_dmem_mask  <= mask_w[B-1:0];
                  end
               end
            end
            ST_REQ0, ST_WAIT0: begin
               // Beat 1 is issued after a store's beat-0 grant or a load's beat-0 data.
               if ((state == ST_REQ0 && i_dmem_gnt) || (state == ST_WAIT0 && i_dmem_rvalid)) begin
                  if (state == ST_WAIT0) rdata0_q <= i_dmem_rdata;
                  o_dmem_req <= 1'b0;
                  o_dmem_ren <= 1'b0;
                  o_dmem_wen <= 1'b0;
                  if (state == ST_REQ0 && req_load) begin
                     state      <= ST_WAIT0;
                  end else if (req_cross) begin
                     state        <= ST_REQ1;
                     o_dmem_req   <= 1'b1;
                     o_dmem_ren   <= req_load;
                     o_dmem_wen   <= ~req_load;
                     o_dmem_addr  <= o_dmem_addr + XLEN'(B);
                     o_dmem_wdata <= wdata1;
                     o_dmem_mask  <= mask_w[MW-1:B];
                  end else begin
                     state       <= ST_RESP;
                     o_done      <= 1'b1;
                     o_load_data <= req_load ? load_val : '0;
                  end
               end
            end
            ST_REQ1: begin
               if (i_dmem_gnt) begin
                  o_dmem_req <= 1'b0;
                  o_dmem_ren <= 1'b0;
                  o_dmem_wen <= 1'b0;
                  if (req_load) begin
                     state <= ST_WAIT1;
                  end else begin
                     state       <= ST_RESP;
                     o_done      <= 1'b1;
                     o_load_data <= '0;
                  end
               end
            end
            ST_WAIT1: begin
               if (i_dmem_rvalid) begin
                  state       <= ST_RESP;
                  o_done      <= 1'b1;
                  o_load_data <= load_val;
               end
            end
            ST_RESP: begin
               state        <= ST_IDLE;
               o_busy       <= 1'b0;
               o_done       <= 1'b0;
               o_misaligned <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32): vector table plus corner-case sequences.
// A second instance with MISALIGN_SPLIT=0 covers the misaligned-flag path.
// Memory handshake is driven by the bench: gnt in the request cycle, rvalid the cycle after.
module tb_load_store_unit;

   logic        clk, rst_n, req, req2, rd, wr, gnt, rvalid;
   logic [2:0]  f3;
   logic [31:0] addr, wdata, rdata;

   logic        busy, done, mis, dreq, ren, wen;
   logic [31:0] daddr, dwdata, ldata;
   logic [3:0]  dmask;

   logic        f_busy, f_done, f_mis, f_dreq, f_ren, f_wen;
   logic [31:0] f_daddr, f_dwdata, f_ldata;
   logic [3:0]  f_dmask;

   int tests = 0;
   int fails = 0;

   load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mem_read(rd), .i_mem_write(wr),
      .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
      .o_busy(busy), .o_done(done), .o_load_data(ldata), .o_misaligned(mis),
      .o_dmem_req(dreq), .i_dmem_gnt(gnt), .o_dmem_addr(daddr), .o_dmem_ren(ren),
      .o_dmem_wen(wen), .o_dmem_wdata(dwdata), .o_dmem_mask(dmask),
      .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata));

   load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(0)) u_flag (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_mem_read(rd), .i_mem_write(wr),
      .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
      .o_busy(f_busy), .o_done(f_done), .o_load_data(f_ldata), .o_misaligned(f_mis),
      .o_dmem_req(f_dreq), .i_dmem_gnt(gnt), .o_dmem_addr(f_daddr), .o_dmem_ren(f_ren),
      .o_dmem_wen(f_wen), .o_dmem_wdata(f_dwdata), .o_dmem_mask(f_dmask),
      .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rd0, rd1;
      int          nbeats;
      logic [31:0] a0;
      logic [3:0]  m0;
      logic [31:0] w0, a1;
      logic [3:0]  m1;
      logic [31:0] w1, ld;
      int          lat;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] r0, input logic [31:0] r1, input int nb,
                               input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                               input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
                               input logic [31:0] ld, input int lat);
      vec_t v;
      v.rd = r; v.wr = w; v.f3 = f; v.addr = a; v.wdata = wd; v.rd0 = r0; v.rd1 = r1;
      v.nbeats = nb; v.a0 = a0; v.m0 = m0; v.w0 = w0; v.a1 = a1; v.m1 = m1; v.w1 = w1;
      v.ld = ld; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] outs_main();
      return {busy, done, mis, dreq, ren, wen, daddr, dwdata, dmask, ldata};
   endfunction

   function automatic logic [127:0] outs_flag();
      return {f_busy, f_done, f_mis, f_dreq, f_ren, f_wen, f_daddr, f_dwdata, f_dmask, f_ldata};
   endfunction

   // One access: request pulse, then a cycle-by-cycle memory responder until o_done.
   task automatic run_vec(input vec_t v, input string tag);
      int   cyc, b, rv_b;
      logic rv_pend, fin;
      @(negedge clk);
      req = 1'b1; rd = v.rd; wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      @(negedge clk);
      req = 1'b0;
      cyc = 1; b = 0; rv_b = 0; rv_pend = 1'b0; fin = 1'b0;
      while (!fin && cyc < 40) begin
         gnt = 1'b0; rvalid = 1'b0; rdata = '0;
         if (done) begin
            chk({tag, ".latency"}, 128'(cyc), 128'(v.lat));
            chk({tag, ".load_data"}, ldata, v.ld);
            chk({tag, ".misaligned"}, mis, 1'b0);
            chk({tag, ".beats"}, 128'(b), 128'(v.nbeats));
            fin = 1'b1;
         end else begin
            chk({tag, ".busy"}, busy, 1'b1);
            if (rv_pend) begin
               rvalid = 1'b1;
               rdata = (rv_b == 0) ? v.rd0 : v.rd1;
               rv_pend = 1'b0;
            end else if (dreq) begin
               chk($sformatf("%s.b%0d.addr", tag, b), daddr, (b == 0) ? v.a0 : v.a1);
               chk($sformatf("%s.b%0d.mask", tag, b), dmask, (b == 0) ? v.m0 : v.m1);
               chk($sformatf("%s.b%0d.wdata", tag, b), dwdata, (b == 0) ? v.w0 : v.w1);
               chk($sformatf("%s.b%0d.ren_wen", tag, b), {ren, wen}, {v.rd, v.wr & ~v.rd});
               gnt = 1'b1;
               if (v.rd) begin
                  rv_pend = 1'b1;
                  rv_b = b;
               end
               b++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk({tag, ".done_timeout"}, 1'b0, 1'b1);
      gnt = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      chk({tag, ".idle_after"}, {busy, done}, 2'b00);
   endtask

   vec_t vecs[14];
   vec_t rv;

   initial begin
      int   n;
      logic saw, found;

      rst_n = 1'b0; req = 1'b0; req2 = 1'b0; rd = 1'b0; wr = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      f3 = '0; addr = '0; wdata = '0; rdata = '0;

      vecs[0]  = mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 1,
                    32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h0, 2);
      vecs[1]  = mk(1, 0, 3'b000, 32'h103, 0, 32'h80000000, 0, 1,
                    32'h100, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80, 3);
      vecs[2]  = mk(1, 0, 3'b100, 32'h103, 0, 32'h80000000, 0, 1,
                    32'h100, 4'h8, 0, 0, 0, 0, 32'h00000080, 3);
      vecs[3]  = mk(0, 1, 3'b010, 32'h102, 32'hAABBCCDD, 0, 0, 2,
                    32'h100, 4'hC, 32'hCCDD0000, 32'h104, 4'h3, 32'h0000AABB, 32'h0, 3);
      vecs[4]  = mk(1, 0, 3'b001, 32'h103, 0, 32'h34000000, 32'h00000012, 2,
                    32'h100, 4'h8, 0, 32'h104, 4'h1, 0, 32'h00001234, 5);
      vecs[5]  = mk(1, 0, 3'b001, 32'h103, 0, 32'h34000000, 32'h00000092, 2,
                    32'h100, 4'h8, 0, 32'h104, 4'h1, 0, 32'hFFFF9234, 5);
      vecs[6]  = mk(0, 1, 3'b001, 32'h101, 32'h1234ABCD, 0, 0, 1,
                    32'h100, 4'h6, 32'h34ABCD00, 0, 0, 0, 32'h0, 2);
      vecs[7]  = mk(1, 0, 3'b010, 32'h208, 0, 32'h13579BDF, 0, 1,
                    32'h208, 4'hF, 0, 0, 0, 0, 32'h13579BDF, 3);
      vecs[8]  = mk(1, 0, 3'b101, 32'h102, 0, 32'hF00D1234, 0, 1,
                    32'h100, 4'hC, 0, 0, 0, 0, 32'h0000F00D, 3);
      vecs[9]  = mk(1, 0, 3'b001, 32'h102, 0, 32'hF00D1234, 0, 1,
                    32'h100, 4'hC, 0, 0, 0, 0, 32'hFFFFF00D, 3);
      vecs[10] = mk(0, 1, 3'b000, 32'h0F1, 32'h000000A5, 0, 0, 1,
                    32'h0F0, 4'h2, 32'h0000A500, 0, 0, 0, 32'h0, 2);
      vecs[11] = mk(1, 0, 3'b010, 32'h101, 0, 32'h44332211, 32'h88776655, 2,
                    32'h100, 4'hE, 0, 32'h104, 4'h1, 0, 32'h55443322, 5);
      vecs[12] = mk(0, 1, 3'b011, 32'h000, 32'h01020304, 0, 0, 1,
                    32'h000, 4'hF, 32'h01020304, 0, 0, 0, 32'h0, 2);
      vecs[13] = mk(1, 1, 3'b010, 32'h010, 0, 32'h0BADF00D, 0, 1,
                    32'h010, 4'hF, 0, 0, 0, 0, 32'h0BADF00D, 3);

      // Reset state
      #1;
      chk("reset.main_outputs", outs_main(), 128'h0);
      chk("reset.flag_outputs", outs_flag(), 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Grant withheld three cycles in REQ0, with a competing request that must be ignored
      @(negedge clk);
      req = 1'b1; rd = 1'b0; wr = 1'b1; f3 = 3'b010; addr = 32'h204; wdata = 32'h11223344;
      @(negedge clk);
      req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("hold.c%0d", k), {busy, done, mis, dreq, ren, wen, daddr, dwdata, dmask},
             {6'b100101, 32'h204, 32'h11223344, 4'hF});
         if (k < 3) begin
            req = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h300; wdata = 32'h0;
            @(negedge clk);
         end
      end
      req = 1'b0; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("hold.done", {done, dreq}, 2'b10);
      @(negedge clk);
      chk("hold.idle1", {busy, dreq}, 2'b00);
      @(negedge clk);
      chk("hold.idle2", {busy, dreq}, 2'b00);

      // Misaligned-flag path on the non-splitting instance
      @(negedge clk);
      req2 = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h101; wdata = '0;
      @(negedge clk);
      req2 = 1'b0;
      n = 0; saw = 1'b0; found = 1'b0;
      while (!found && n < 10) begin
         if (f_dreq) saw = 1'b1;
         if (f_done) begin
            chk("flag.misaligned", f_mis, 1'b1);
            chk("flag.load_data", f_ldata, 32'h0);
            found = 1'b1;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      chk("flag.done_seen", found, 1'b1);
      chk("flag.no_dmem_req", saw, 1'b0);
      @(negedge clk);
      chk("flag.idle_after", {f_busy, f_done, f_mis}, 3'b000);

      // Reset asserted while waiting for beat-1 data
      @(negedge clk);
      req = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h101; wdata = '0;
      @(negedge clk);
      req = 1'b0;
      chk("rst.req0", dreq, 1'b1);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h44332211;
      @(negedge clk);
      rvalid = 1'b0; rdata = '0;
      chk("rst.req1", {dreq, daddr}, {1'b1, 32'h104});
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("rst.wait1", {busy, dreq}, 2'b10);
      rst_n = 1'b0;
      #1;
      chk("rst.async_clear", outs_main(), 128'h0);
      @(negedge clk);
      chk("rst.held_clear", outs_main(), 128'h0);
      rst_n = 1'b1;
      rv = mk(1, 0, 3'b010, 32'h0, 0, 32'hCAFEF00D, 0, 1,
              32'h0, 4'hF, 0, 0, 0, 0, 32'hCAFEF00D, 3);
      run_vec(rv, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
